// File: rtl/shift_add_multiplier_pkg.sv
// Shared types and sizing for the shift-and-add multiplier.
package shift_add_multiplier_pkg;

  localparam int WIDTH_DEFAULT = 32;

  // Counter must hold values up to WIDTH, hence one bit beyond log2.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

  localparam int CNT_W = cnt_width(WIDTH_DEFAULT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/shift_add_multiplier_datapath.sv
// Multiplicand register, 65-bit accumulator, 33-bit adder and right shifter.
// The product register is written only when the controller signals the last
// step, so the output never exposes partial sums.
module shift_add_multiplier_datapath
  import shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 calc,
  input  logic                 write_result,
  input  logic [WIDTH-1:0]     m_plier,
  input  logic [WIDTH-1:0]     m_cand,
  output logic [2*WIDTH-1:0]   product
);

  logic [WIDTH-1:0] mcand;
  logic [2*WIDTH:0] acc;
  logic [2*WIDTH:0] acc_next;
  logic [WIDTH:0]   upper;

  // One shift-add step: conditionally add the multiplicand into the upper
  // WIDTH+1 bits (carry kept), then shift the whole accumulator right by one.
  // NOTE: every combinational output gets a default assignment first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    upper = acc[2*WIDTH:WIDTH];
    if (acc[0]) begin
      upper = acc[2*WIDTH:WIDTH] + {1'b0, mcand};
    end
    acc_next = {1'b0, upper, acc[WIDTH-1:1]};
  end

  // Operand capture on start, one accumulator step per CALC cycle.
  // NOTE: these are plain registers, not a memory array, so clearing them on
  // reset is cheap and keeps the post-reset state fully defined.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0;
      acc   <= '0;
    end else if (load) begin
      mcand <= m_cand;
      acc   <= {{(WIDTH + 1){1'b0}}, m_plier};
    end else if (calc) begin
      acc <= acc_next;
    end
  end

  // Result register: takes the final shifted value, holds it otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product <= '0;
    end else if (write_result) begin
      product <= acc_next[2*WIDTH-1:0];
    end
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned WIDTHxWIDTH multiplier, one multiplier bit per clock.
// A start in IDLE or FINISH launches an operation; DONE rises WIDTH edges
// after the start edge and stays high with PRODUCT until the next start.
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 ST,
  input  logic [WIDTH-1:0]     M_PLIER,
  input  logic [WIDTH-1:0]     M_CAND,
  output logic                 DONE,
  output logic [2*WIDTH-1:0]   PRODUCT
);

  localparam int CW = cnt_width(WIDTH);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] count;
  logic          load;
  logic          calc;
  logic          last;

  // State register.
  // NOTE: sequential state is always assigned with non-blocking <= so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: ST is only honoured outside CALC.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (ST)   state_next = CALC;
      CALC:    if (last) state_next = FINISH;
      FINISH:  if (ST)   state_next = CALC;
      default:           state_next = IDLE;
    endcase
  end

  // Control decode for the datapath and the step counter.
  always_comb begin
    load = ST && ((state == IDLE) || (state == FINISH));
    calc = (state == CALC);
    last = calc && (count == CW'(WIDTH - 1));
  end

  // Step counter: cleared on start, advanced once per CALC cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (calc) begin
      count <= count + CW'(1);
    end
  end

  // DONE flag: drops on a new start, rises with the result write.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      DONE <= 1'b0;
    end else if (load) begin
      DONE <= 1'b0;
    end else if (last) begin
      DONE <= 1'b1;
    end
  end

  shift_add_multiplier_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk          (CLK),
    .rst_n        (RST),
    .load         (load),
    .calc         (calc),
    .write_result (last),
    .m_plier      (M_PLIER),
    .m_cand       (M_CAND),
    .product      (PRODUCT)
  );

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier: stimulus pushes hand-computed
// products with their start cycle; a monitor pops on each DONE rise and
// checks both value and latency.
module tb_shift_add_multiplier;

  localparam int LAT = 32;

  typedef struct {
    logic [63:0] prod;
    int          start;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        ST = 1'b0;
  logic [31:0] M_PLIER = '0;
  logic [31:0] M_CAND = '0;
  logic        DONE;
  logic [63:0] PRODUCT;

  int   n_vec = 0;
  int   n_miss = 0;
  int   cyc = 0;
  logic done_prev = 1'b0;
  exp_t exp_q[$];

  shift_add_multiplier dut (
    .CLK     (CLK),
    .RST     (RST),
    .ST      (ST),
    .M_PLIER (M_PLIER),
    .M_CAND  (M_CAND),
    .DONE    (DONE),
    .PRODUCT (PRODUCT)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every DONE rise must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (DONE === 1'b1 && done_prev !== 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("product", PRODUCT, e.prod);
        check("latency", 64'(cyc - e.start), 64'(LAT));
      end
    end
    done_prev <= DONE;
  end

  // Launch one operation with a single-edge ST pulse; returns the start cycle.
  task automatic start_op(input logic [31:0] mp, input logic [31:0] mc,
                          input bit push, input logic [63:0] prod, output int s);
    exp_t e;
    @(negedge CLK);
    M_PLIER = mp;
    M_CAND  = mc;
    ST      = 1'b1;
    @(posedge CLK);
    #1;
    s = cyc;
    if (push) begin
      e.prod  = prod;
      e.start = s;
      exp_q.push_back(e);
    end
    @(negedge CLK);
    ST = 1'b0;
  endtask

  // Bounded wait for the scoreboard to empty.
  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    @(negedge CLK);
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int s;
    bit bad;

    // Asynchronous reset between edges clears outputs at once.
    #2;
    check("reset_done", {63'd0, DONE}, 64'd0);
    check("reset_product", PRODUCT, 64'd0);
    @(negedge CLK);
    RST = 1'b1;

    bad = 1'b0;
    repeat (50) begin
      @(negedge CLK);
      if (DONE !== 1'b0 || PRODUCT !== 64'd0) bad = 1'b1;
    end
    check("idle_quiet", {63'd0, bad}, 64'd0);

    // Basic vector, then hold check.
    start_op(32'hE94EA3FF, 32'h0000_0002, 1'b1, 64'h0000_0001_D29D_47FE, s);
    drain("basic_drain");
    repeat (20) @(negedge CLK);
    check("hold_done", {63'd0, DONE}, 64'd1);
    check("hold_product", PRODUCT, 64'h0000_0001_D29D_47FE);

    // Back-to-back from FINISH: DONE drops on start edge, PRODUCT unchanged.
    @(negedge CLK);
    M_PLIER = 32'h0000_FFFF;
    M_CAND  = 32'h0001_0001;
    ST      = 1'b1;
    begin
      exp_t e;
      e.prod = 64'h0000_0000_FFFF_FFFF;
      @(posedge CLK);
      #1;
      e.start = cyc;
      exp_q.push_back(e);
    end
    check("b2b_done_low", {63'd0, DONE}, 64'd0);
    check("b2b_old_product", PRODUCT, 64'h0000_0001_D29D_47FE);
    @(negedge CLK);
    ST = 1'b0;
    repeat (5) @(negedge CLK);
    check("no_partial_product", PRODUCT, 64'h0000_0001_D29D_47FE);
    drain("b2b_drain");

    // Extremes and a few small patterns.
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFE_0000_0001, s);
    drain("max_drain");
    start_op(32'h0000_0000, 32'h1234_5678, 1'b1, 64'h0, s);
    drain("zero_drain");
    start_op(32'h0000_0001, 32'h8000_0000, 1'b1, 64'h0000_0000_8000_0000, s);
    drain("one_drain");
    start_op(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, s);
    drain("msb_drain");
    start_op(32'h0000_0003, 32'h0000_0005, 1'b1, 64'd15, s);
    drain("small_drain");

    // Operand change and ST pulse during CALC are ignored.
    start_op(32'h0000_0007, 32'h0000_0009, 1'b1, 64'd63, s);
    while (cyc < s + 9) @(negedge CLK);
    M_PLIER = 32'hFFFF_FFFF;
    M_CAND  = 32'hFFFF_FFFF;
    ST      = 1'b1;
    @(negedge CLK);
    ST = 1'b0;
    drain("calc_ignore_drain");

    // ST held high: restart on the FINISH edge, DONE pulses one cycle.
    @(negedge CLK);
    M_PLIER = 32'h0000_0010;
    M_CAND  = 32'h0000_0010;
    ST      = 1'b1;
    @(posedge CLK);
    #1;
    s = cyc;
    begin
      exp_t e;
      e.prod  = 64'h100;
      e.start = s;
      exp_q.push_back(e);
      e.start = s + LAT + 1;
      exp_q.push_back(e);
    end
    while (cyc < s + LAT + 1) @(negedge CLK);
    ST = 1'b0;
    check("held_st_done_pulse", {63'd0, DONE}, 64'd0);
    drain("held_st_drain");

    // Async reset between edges from FINISH.
    @(negedge CLK);
    #2;
    RST = 1'b0;
    #1;
    check("async_rst_done", {63'd0, DONE}, 64'd0);
    check("async_rst_product", PRODUCT, 64'd0);
    @(negedge CLK);
    RST = 1'b1;

    // Reset mid-operation discards the work in flight.
    start_op(32'h0000_0005, 32'h0000_0005, 1'b0, 64'd0, s);
    while (cyc < s + 15) @(negedge CLK);
    #2;
    RST = 1'b0;
    #1;
    check("midop_rst_done", {63'd0, DONE}, 64'd0);
    check("midop_rst_product", PRODUCT, 64'd0);
    @(negedge CLK);
    RST = 1'b1;
    repeat (40) @(negedge CLK);
    check("midop_no_result", {63'd0, DONE}, 64'd0);
    start_op(32'h0000_0006, 32'h0000_0007, 1'b1, 64'd42, s);
    drain("after_rst_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
